// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: serial receive front end, 8N1 (8 data bits, LSB first,
// one stop bit, idle high). Produces RX_data with a one-cycle byte_done strobe.
// Bit timing comes from a clock-cycle counter sampling at mid-bit.
// Optional build macro UART_RX_PARITY_EN adds one even-parity bit before
// the stop bit and drives parity_err; otherwise parity_err is tied low.
module uart_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] RX_data,
   output logic       byte_done,
   output logic       frame_err,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t           state, state_n;
   logic             rx_q1, rx_s;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       sh, sh_n;
   logic [7:0]       data_n;
   logic             done_n, ferr_n, busy_n;
`ifdef UART_RX_PARITY_EN
   logic             par, par_n;
   logic             perr_n;
`endif

   // Two-flop synchroniser; idle-high reset value avoids a false start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         rx_q1 <= rx;
         rx_s  <= rx_q1;
      end
   end

   // Next-state, datapath and output decode.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt + CNT_W'(1);
      bit_idx_n = bit_idx;
      sh_n      = sh;
      data_n    = RX_data;
      done_n    = 1'b0;
      ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_n     = par;
      perr_n    = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_idx_n = 3'd0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n     = '0;
               sh_n      = {rx_s, sh[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               par_n   = rx_s;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  // Framing error wins over any parity result.
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end else begin
                  state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                  if ((^sh) ^ par) begin
                     perr_n = 1'b1;
                  end else begin
                     data_n = sh;
                     done_n = 1'b1;
                  end
`else
                  data_n = sh;
                  done_n = 1'b1;
`endif
               end
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // State, datapath and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         sh        <= 8'h00;
         RX_data   <= 8'h00;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         sh        <= sh_n;
         RX_data   <= data_n;
         byte_done <= done_n;
         frame_err <= ferr_n;
         rx_busy   <= busy_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Captured parity bit and its error strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par        <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par        <= par_n;
         parity_err <= perr_n;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
